// File: rtl/alu_b_pkg.sv
// Shared constants for the alu_b block: default datapath width and opcode encodings.
package alu_b_pkg;

    localparam int ALU_B_WIDTH = 32;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_DEF  = 3'b111;

endpackage

// File: rtl/alu_b_core.sv
// Combinational datapath of alu_b: maps (A, B, sel) to the next result.
// Build option: define ALU_B_MUL_EN to include the multiplier for OP_MUL;
// without it OP_MUL yields zero and no multiplier is built.
module alu_b_core
    import alu_b_pkg::*;
#(
    parameter int WIDTH = ALU_B_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] res
);

    // Select the operation; all arithmetic is unsigned and wraps modulo 2^WIDTH.
    always_comb begin
        res = '0;
        case (sel)
            OP_ADD: res = A + B;
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
`ifdef ALU_B_MUL_EN
            OP_MUL: res = A * B;
`else
            OP_MUL: res = '0;
`endif
            OP_SUB: res = A - B;
            OP_SLT: res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_b.sv
// alu_b top: registers the core result and its zero flag with 1-cycle latency.
// Handshake: in_valid qualifies A/B/sel in the cycle it is high (no ready, the
// block accepts one operation every cycle); out_valid is high in the cycle
// after an accepted operation, and R/Z hold their value while it is low.
// Build option: ALU_B_MUL_EN (see alu_b_core).
module alu_b
    import alu_b_pkg::*;
#(
    parameter int WIDTH = ALU_B_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             out_valid
);

    logic [WIDTH-1:0] next_r;

    alu_b_core #(.WIDTH(WIDTH)) u_core (
        .A   (A),
        .B   (B),
        .sel (sel),
        .res (next_r)
    );

    // Output registers; reset wins over a simultaneous valid operation, and Z
    // is derived from next_r so it lands on the same edge as R.
    always_ff @(posedge clk) begin
        if (rst) begin
            R         <= '0;
            Z         <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                R <= next_r;
                Z <= (next_r == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_b.sv
// Self-checking bench for alu_b with directed, hand-computed vectors.
module tb_alu_b;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    sel = 3'b000;
    logic          in_valid = 1'b0;
    logic [W-1:0]  r;
    logic          z;
    logic          out_valid;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    alu_b #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .R         (r),
        .Z         (z),
        .out_valid (out_valid)
    );

    // Clock generation
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one valid operation, then check the registered result one edge later.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] sv, input logic [W-1:0] exp_r);
        logic [W-1:0] e;
        @(negedge clk);
        a = av; b = bv; sel = sv; in_valid = 1'b1;
        exp_q.push_back(exp_r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".R"}, r, e);
        check({tag, ".Z"}, {31'd0, z}, {31'd0, (e == '0)});
        check({tag, ".ov"}, {31'd0, out_valid}, 32'd1);
    endtask

    // One idle cycle with changed operands: R/Z must hold, out_valid must drop.
    task automatic run_idle(input string tag, input logic [W-1:0] hold_r, input logic hold_z);
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; sel = 3'b001; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".R"}, r, hold_r);
        check({tag, ".Z"}, {31'd0, z}, {31'd0, hold_z});
        check({tag, ".ov"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state, with in_valid asserted to show reset wins
        rst = 1'b1;
        a = 32'h1; b = 32'h2; sel = 3'b001; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.R", r, 32'h0);
        check("reset.Z", {31'd0, z}, 32'd1);
        check("reset.ov", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Main function, back to back (one op per cycle)
        run_op("add", 32'h10, 32'h20, 3'b001, 32'h30);
        run_op("and", 32'h1, 32'hF, 3'b010, 32'h1);
        run_op("or", 32'h8, 32'hFF, 3'b011, 32'hFF);
`ifdef ALU_B_MUL_EN
        run_op("mul", 32'd4, 32'd5, 3'b100, 32'h14);
        run_op("mul_wrap", 32'h0001_0000, 32'h0001_0000, 3'b100, 32'h0);
        run_op("mul_big", 32'hFFFF_FFFF, 32'h3, 3'b100, 32'hFFFF_FFFD);
`else
        run_op("mul_off", 32'd4, 32'd5, 3'b100, 32'h0);
        run_op("mul_off2", 32'hFFFF_FFFF, 32'h3, 3'b100, 32'h0);
`endif
        run_op("sub", 32'h10, 32'd5, 3'b101, 32'hB);
        run_op("sub_wrap", 32'h0, 32'h1, 3'b101, 32'hFFFF_FFFF);
        run_op("slt_lt", 32'd5, 32'h10, 3'b110, 32'h1);
        run_op("slt_gt", 32'h10, 32'd5, 3'b110, 32'h0);
        run_op("slt_eq", 32'd7, 32'd7, 3'b110, 32'h0);
        run_op("slt_msb", 32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 32'h1);
        run_op("def", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 32'h0);
        run_op("none", 32'h55, 32'hAA, 3'b000, 32'h0);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h2, 3'b001, 32'h1);

        // Hold behaviour: last result was 1, Z=0
        run_idle("hold", 32'h1, 1'b0);
        run_idle("hold2", 32'h1, 1'b0);

        // Nonzero result, then reset during a valid add
        run_op("pre_rst", 32'h100, 32'h23, 3'b011, 32'h123);
        @(negedge clk);
        a = 32'h10; b = 32'h20; sel = 3'b001; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_add.R", r, 32'h0);
        check("rst_add.Z", {31'd0, z}, 32'd1);
        check("rst_add.ov", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Resume right after reset
        run_op("resume", 32'h10, 32'h20, 3'b001, 32'h30);
        run_idle("final_idle", 32'h30, 1'b0);

        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_b.md
ALU_B -- requirements
Module: alu_b

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 A  input  WIDTH  operand A, treated as unsigned.
REQ-005 B  input  WIDTH  operand B, treated as unsigned.
REQ-006 sel  input  3  operation select.
REQ-007 in_valid  input  1  operands and sel valid this cycle.
REQ-008 R  output  WIDTH  registered result.
REQ-009 Z  output  1  registered zero flag, high when R equals 0.
REQ-010 out_valid  output  1  registered; high when R and Z hold a result from the previous cycle's in_valid.

Function
REQ-011 Each rising clk edge with in_valid=1 and rst=0 SHALL register the result of sel into R and Z; latency 1 cycle, throughput 1 operation per cycle.
REQ-012 If in_valid=0, R and Z SHALL hold their values and out_valid SHALL go low next cycle.
REQ-013 sel=001: R = (A + B) mod 2^WIDTH; carry discarded.
REQ-014 sel=010: R = bitwise A AND B.
REQ-015 sel=011: R = bitwise A OR B.
REQ-016 sel=100: R = low WIDTH bits of unsigned A * B; upper product bits discarded.
REQ-017 sel=101: R = (A - B) mod 2^WIDTH; wrap-around on borrow, e.g. 0 - 1 gives all ones.
REQ-018 sel=110: R = 1 if A < B (unsigned), else 0; equal operands give 0.
REQ-019 sel=000 and sel=111: R = 0.
REQ-020 Z SHALL be computed from the next R value, registered in the same edge as R, never one cycle late.
REQ-021 Output SHALL depend only on A, B and sel sampled at the same edge; there is no internal accumulation.

Reset
REQ-022 When rst=1 at a rising edge, R SHALL become 0, Z SHALL become 1 and out_valid SHALL become 0, regardless of in_valid.
REQ-023 Reset SHALL take priority over a simultaneous in_valid; that operation is discarded.
REQ-024 On the first edge after rst deasserts with in_valid=1, normal operation SHALL resume with 1-cycle latency.

Configuration
REQ-025 Macro ALU_B_MUL_EN: when defined, sel=100 SHALL perform the multiply of REQ-016.
REQ-026 When ALU_B_MUL_EN is undefined, no multiplier SHALL be synthesised, and sel=100 SHALL produce R=0, Z=1.

Structure
REQ-027 Package alu_b_pkg SHALL hold the default WIDTH constant and the named opcode constants (OP_NONE=000, OP_ADD=001, OP_AND=010, OP_OR=011, OP_MUL=100, OP_SUB=101, OP_SLT=110, OP_DEF=111).
REQ-028 The combinational datapath SHALL be a sub-module alu_b_core (A, B, sel -> next result). The top alu_b SHALL hold the output registers, the valid flag and the reset logic.

Verification
REQ-029 A=0x10, B=0x20, sel=001, in_valid=1 -> next cycle R=0x30, Z=0, out_valid=1.
REQ-030 A=0x1, B=0xF, sel=010 -> R=0x1. A=0x8, B=0xFF, sel=011 -> R=0xFF. Both with Z=0.
REQ-031 A=4, B=5, sel=100 -> R=0x14 with ALU_B_MUL_EN defined. Same stimulus without the macro -> R=0, Z=1.
REQ-032 A=0x10, B=5, sel=101 -> R=0xB. A=0, B=1, sel=101 -> R=0xFFFFFFFF.
REQ-033 A=5, B=0x10, sel=110 -> R=1. A=0x10, B=5, sel=110 -> R=0, Z=1.
REQ-034 A=B=0xFFFFFFFF, sel=111 -> R=0, Z=1. Assert rst during a valid add -> R=0, Z=1, out_valid=0 on that edge.
